// File: rtl/tx_line_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_line_buf_pkg
// Description : Shared constants and FSM state type for the tx line buffer.
//               ASCII_CR / ASCII_LF : line terminator bytes.
//               state_e             : drain FSM states (2-bit).
// Revision    : 1.0 - initial release
// ============================================================================
package tx_line_buf_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } state_e;

endpackage : tx_line_buf_pkg
`default_nettype wire

// File: rtl/tx_line_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_line_buf_if
// Description : Bus bundle between the cipher/UART side and tx_line_buf.
//   master : drives wr_data, wr_valid, print_req, tx_ready;
//            observes tx_data, tx_valid, count, full, empty, overflow, busy.
//   slave  : the line buffer itself (mirror directions).
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_line_buf_if #(
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          print_req;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          busy;

  modport master (
    output wr_data, wr_valid, print_req, tx_ready,
    input  tx_data, tx_valid, count, full, empty, overflow, busy
  );

  modport slave (
    input  wr_data, wr_valid, print_req, tx_ready,
    output tx_data, tx_valid, count, full, empty, overflow, busy
  );

endinterface : tx_line_buf_if
`default_nettype wire

// File: rtl/tx_line_buf_sync_fifo8.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo8
// Description : Single-clock byte FIFO with show-ahead read port.
//   clk, rst   : clock, asynchronous active-low reset
//   push_i     : store din_i (ignored when full)
//   pop_i      : discard head entry (ignored when empty)
//   din_i      : write byte
//   dout_o     : head byte at rd_ptr (combinational)
//   count_o    : bytes stored
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo8 #(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          push_i,
  input  wire logic          pop_i,
  input  wire logic [7:0]    din_i,
  output      logic [7:0]    dout_o,
  output      logic [CW-1:0] count_o,
  output      logic          full_o,
  output      logic          empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic w_push;
  logic w_pop;

  // Guards use the pre-cycle count, so a push into a full FIFO is dropped
  // even if a pop happens in the same cycle.
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i  && !empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule : sync_fifo8
`default_nettype wire

// File: rtl/tx_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : tx_line_buf
// Description : Buffers cipher output bytes and, on print request, drains
//               them to a UART over valid/ready, optionally ending with CR LF.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of tx_line_buf_if (write strobe, print request,
//              tx valid/ready stream, FIFO status, overflow, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module tx_line_buf
  import tx_line_buf_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter bit ADD_CRLF = 1'b1
) (
  input wire logic    clk,
  input wire logic    rst,
  tx_line_buf_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          overflow_q, overflow_d;
  logic          pend_q, pend_d;

  logic          w_pop;
  logic [7:0]    w_fifo_dout;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_slot_free;
  logic          w_busy;

  sync_fifo8 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.wr_valid),
    .pop_i   (w_pop),
    .din_i   (bus.wr_data),
    .dout_o  (w_fifo_dout),
    .count_o (w_fifo_count),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // Output register can take a new byte when empty or being accepted now.
  assign w_slot_free = !tx_valid_q || bus.tx_ready;
  assign w_busy      = (state_q != IDLE) || tx_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = w_slot_free ? 1'b0 : tx_valid_q;
    overflow_d = overflow_q;
    pend_d     = pend_q || (bus.print_req && w_busy);
    w_pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if ((bus.print_req || pend_q) && w_slot_free) begin
          pend_d     = 1'b0;
          overflow_d = 1'b0;
          // Perform the first drain step in the start cycle so the first
          // byte appears one cycle after the request. An empty buffer with
          // no terminator never leaves IDLE, so busy stays low.
          if (!w_fifo_empty) begin
            w_pop      = 1'b1;
            tx_data_d  = w_fifo_dout;
            tx_valid_d = 1'b1;
            state_d    = DRAIN;
          end else if (ADD_CRLF) begin
            state_d = CR;
          end
        end
      end
      DRAIN: begin
        if (w_slot_free) begin
          if (!w_fifo_empty) begin
            w_pop      = 1'b1;
            tx_data_d  = w_fifo_dout;
            tx_valid_d = 1'b1;
          end else if (ADD_CRLF) begin
            // Emit CR straight away to keep the stream gap-free.
            tx_data_d  = ASCII_CR;
            tx_valid_d = 1'b1;
            state_d    = LF;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CR: begin
        if (w_slot_free) begin
          tx_data_d  = ASCII_CR;
          tx_valid_d = 1'b1;
          state_d    = LF;
        end
      end
      LF: begin
        if (w_slot_free) begin
          tx_data_d  = ASCII_LF;
          tx_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A dropped write in the start cycle still reports overflow.
    if (bus.wr_valid && w_fifo_full) overflow_d = 1'b1;
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.count    = w_fifo_count;
  assign bus.full     = w_fifo_full;
  assign bus.empty    = w_fifo_empty;
  assign bus.overflow = overflow_q;
  assign bus.busy     = w_busy;

endmodule : tx_line_buf
`default_nettype wire

// File: tb/tb_tx_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_line_buf
// Description : Self-checking bench for tx_line_buf. Two instances share the
//               clock and reset: dut (DEPTH=4, CR LF enabled) and dut0
//               (DEPTH=4, no terminator). Accepted output bytes are logged
//               and compared with sequences derived from the written data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_line_buf;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tx_line_buf_if #(.DEPTH(4)) bus  ();
  tx_line_buf_if #(.DEPTH(4)) bus0 ();

  tx_line_buf #(.DEPTH(4), .ADD_CRLF(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  tx_line_buf #(.DEPTH(4), .ADD_CRLF(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] obs[$];
  int         obs_cyc[$];
  logic [7:0] obs0[$];
  bit         seen_valid0 = 1'b0;
  bit         seen_busy0  = 1'b0;

  // Inputs change 1 time unit after posedge; the negedge sample therefore
  // shows exactly what the next posedge will act on.
  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready) begin
      obs.push_back(bus.tx_data);
      obs_cyc.push_back(cyc);
    end
    if (bus0.tx_valid && bus0.tx_ready) obs0.push_back(bus0.tx_data);
    if (bus0.tx_valid) seen_valid0 = 1'b1;
    if (bus0.busy)     seen_busy0  = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic write_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      bus.wr_data  = b[i];
      bus.wr_valid = 1'b1;
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic print_pulse();
    bus.print_req = 1'b1;
    tick();
    bus.print_req = 1'b0;
  endtask

  task automatic test_reset();
    n_total++; if (bus.count !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.count); else n_pass++;
    n_total++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got %b want 1", bus.empty); else n_pass++;
    n_total++; if (bus.full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.full); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", bus.overflow); else n_pass++;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", bus.tx_data); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] exp[$];
    int pc;
    bit ok;
    obs.delete(); obs_cyc.delete();
    bus.tx_ready = 1'b1;
    write_bytes('{8'h48, 8'h69});
    pc = cyc;
    print_pulse();
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL basic_timeout busy still high"); else n_pass++;
    exp = '{8'h48, 8'h69, 8'h0D, 8'h0A};
    n_total++; if (obs.size() != exp.size()) $display("FAIL basic_len got %0d want %0d", obs.size(), exp.size()); else n_pass++;
    foreach (exp[i]) begin
      if (i < obs.size()) begin
        n_total++; if (obs[i] !== exp[i]) $display("FAIL basic_byte%0d got %h want %h", i, obs[i], exp[i]); else n_pass++;
        if (i > 0) begin
          n_total++;
          if (obs_cyc[i] != obs_cyc[i-1] + 1) $display("FAIL basic_gap%0d got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[i-1] + 1);
          else n_pass++;
        end
      end
    end
    if (obs_cyc.size() > 0) begin
      n_total++; if (obs_cyc[0] != pc + 1) $display("FAIL basic_latency got cycle %0d want %0d", obs_cyc[0], pc + 1); else n_pass++;
    end
    n_total++; if (bus.busy !== 1'b0) $display("FAIL basic_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.empty !== 1'b1) $display("FAIL basic_empty got %b want 1", bus.empty); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    bit ok;
    obs.delete(); obs_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      bus.wr_data  = 8'h41 + 8'(i);
      bus.wr_valid = 1'b1;
      tick();
      if (i == 3) begin
        n_total++; if (bus.full !== 1'b1) $display("FAIL ovf_full got %b want 1", bus.full); else n_pass++;
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", bus.overflow); else n_pass++;
      end
    end
    bus.wr_valid = 1'b0;
    n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.overflow); else n_pass++;
    n_total++; if (bus.count !== 3'd4) $display("FAIL ovf_count got %0d want 4", bus.count); else n_pass++;
    print_pulse();
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", bus.overflow); else n_pass++;
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL ovf_timeout busy still high"); else n_pass++;
    exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    n_total++; if (obs.size() != exp.size()) $display("FAIL ovf_len got %0d want %0d", obs.size(), exp.size()); else n_pass++;
    foreach (exp[i]) if (i < obs.size()) begin
      n_total++; if (obs[i] !== exp[i]) $display("FAIL ovf_byte%0d got %h want %h", i, obs[i], exp[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$];
    bit ok;
    obs.delete(); obs_cyc.delete();
    write_bytes('{8'h31, 8'h32});
    bus.tx_ready = 1'b0;
    print_pulse();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h31)
        $display("FAIL bp_hold%0d got valid=%b data=%h want valid=1 data=31", i, bus.tx_valid, bus.tx_data);
      else n_pass++;
      tick();
    end
    bus.tx_ready = 1'b1;
    tick();
    n_total++; if (bus.tx_data !== 8'h32 || bus.tx_valid !== 1'b1) $display("FAIL bp_next got valid=%b data=%h want valid=1 data=32", bus.tx_valid, bus.tx_data); else n_pass++;
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL bp_timeout busy still high"); else n_pass++;
    exp = '{8'h31, 8'h32, 8'h0D, 8'h0A};
    n_total++; if (obs.size() != exp.size()) $display("FAIL bp_len got %0d want %0d", obs.size(), exp.size()); else n_pass++;
    foreach (exp[i]) if (i < obs.size()) begin
      n_total++; if (obs[i] !== exp[i]) $display("FAIL bp_byte%0d got %h want %h", i, obs[i], exp[i]); else n_pass++;
    end
  endtask

  task automatic test_pend();
    logic [7:0] exp[$];
    bit ok;
    obs.delete(); obs_cyc.delete();
    write_bytes('{8'h51, 8'h52});
    print_pulse();
    print_pulse();
    print_pulse();
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL pend_timeout busy still high"); else n_pass++;
    exp = '{8'h51, 8'h52, 8'h0D, 8'h0A, 8'h0D, 8'h0A};
    n_total++; if (obs.size() != exp.size()) $display("FAIL pend_len got %0d want %0d", obs.size(), exp.size()); else n_pass++;
    foreach (exp[i]) if (i < obs.size()) begin
      n_total++; if (obs[i] !== exp[i]) $display("FAIL pend_byte%0d got %h want %h", i, obs[i], exp[i]); else n_pass++;
    end
  endtask

  task automatic test_no_crlf();
    seen_valid0 = 1'b0;
    seen_busy0  = 1'b0;
    obs0.delete();
    bus0.print_req = 1'b1;
    tick();
    bus0.print_req = 1'b0;
    repeat (8) tick();
    n_total++; if (seen_valid0 !== 1'b0) $display("FAIL nocrlf_valid got 1 want 0"); else n_pass++;
    n_total++; if (seen_busy0 !== 1'b0) $display("FAIL nocrlf_busy got 1 want 0"); else n_pass++;
    bus0.wr_data = 8'h55; bus0.wr_valid = 1'b1; tick();
    bus0.wr_data = 8'h66; tick();
    bus0.wr_valid = 1'b0;
    bus0.print_req = 1'b1; tick(); bus0.print_req = 1'b0;
    repeat (10) tick();
    n_total++; if (obs0.size() != 2) $display("FAIL nocrlf_len got %0d want 2", obs0.size()); else n_pass++;
    if (obs0.size() >= 2) begin
      n_total++; if (obs0[0] !== 8'h55 || obs0[1] !== 8'h66) $display("FAIL nocrlf_data got %h %h want 55 66", obs0[0], obs0[1]); else n_pass++;
    end
    n_total++; if (bus0.busy !== 1'b0) $display("FAIL nocrlf_idle got %b want 0", bus0.busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    obs.delete(); obs_cyc.delete();
    write_bytes('{8'h61, 8'h62, 8'h63});
    print_pulse();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (obs.size() >= 1) begin ok = 1'b1; break; end
      tick();
    end
    n_total++; if (!ok) $display("FAIL rstmid_first_byte got none want 61"); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.count !== 3'd0) $display("FAIL rstmid_count got %0d want 0", bus.count); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    obs.delete(); obs_cyc.delete();
    print_pulse();
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL rstmid_timeout busy still high"); else n_pass++;
    n_total++; if (obs.size() != 2) $display("FAIL rstmid_len got %0d want 2", obs.size()); else n_pass++;
    if (obs.size() >= 2) begin
      n_total++; if (obs[0] !== 8'h0D || obs[1] !== 8'h0A) $display("FAIL rstmid_seq got %h %h want 0d 0a", obs[0], obs[1]); else n_pass++;
    end
  endtask

  // Model: every written byte must come out once, in order; terminators
  // appear only as adjacent 0D 0A pairs (data bytes are printable ASCII).
  task automatic test_random();
    logic [7:0] exp[$];
    int crlf = 0;
    int i = 0;
    bit ok;
    obs.delete(); obs_cyc.delete();
    for (int c = 0; c < 400; c++) begin
      bus.wr_valid = !bus.full && ($urandom % 3 == 0);
      bus.wr_data  = 8'($urandom_range(8'h20, 8'h7E));
      if (bus.wr_valid) exp.push_back(bus.wr_data);
      bus.print_req = ($urandom % 6 == 0);
      bus.tx_ready  = ($urandom % 2 == 0);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.tx_ready = 1'b1;
    print_pulse();
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL rand_timeout busy still high"); else n_pass++;
    while (i < obs.size()) begin
      n_total++;
      if (obs[i] === 8'h0D) begin
        if (i + 1 >= obs.size() || obs[i+1] !== 8'h0A) $display("FAIL rand_term at %0d CR not followed by 0a", i);
        else n_pass++;
        crlf++;
        i += 2;
      end else begin
        if (exp.size() == 0) $display("FAIL rand_extra got %h want nothing", obs[i]);
        else if (obs[i] !== exp[0]) $display("FAIL rand_byte%0d got %h want %h", i, obs[i], exp[0]);
        else n_pass++;
        if (exp.size() != 0) void'(exp.pop_front());
        i++;
      end
    end
    n_total++; if (exp.size() != 0) $display("FAIL rand_missing got %0d unsent want 0", exp.size()); else n_pass++;
    n_total++; if (crlf < 1) $display("FAIL rand_crlf got %0d want >=1", crlf); else n_pass++;
    n_total++; if (bus.empty !== 1'b1) $display("FAIL rand_empty got %b want 1", bus.empty); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL rand_overflow got %b want 0", bus.overflow); else n_pass++;
  endtask

  initial begin
    bus.wr_data = 8'h00; bus.wr_valid = 1'b0; bus.print_req = 1'b0; bus.tx_ready = 1'b1;
    bus0.wr_data = 8'h00; bus0.wr_valid = 1'b0; bus0.print_req = 1'b0; bus0.tx_ready = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_basic();
    test_overflow();
    test_backpressure();
    test_pend();
    test_no_crlf();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_tx_line_buf
`default_nettype wire

// File: doc/tx_line_buf.md
Name: tx_line_buf

Overview:
- Downstream stage of the stream-cipher top level.
- Captures the byte stream the cipher emits (tx byte + data-ready strobe) into a line FIFO.
- On a print-buffer request, drains the FIFO to the UART transmitter over a valid/ready handshake, optionally terminated by CR LF.
- Decouples cipher output bursts (one byte per cycle) from the slow UART serializer.

Parameters:
- DEPTH, 32, FIFO capacity in bytes; power of two, >= 2.
- ADD_CRLF, 1, when 1 each drain pass ends with 0x0D then 0x0A; when 0 no terminator.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- wr_data  in  8  byte from cipher datapath.
- wr_valid  in  1  wr_data valid this cycle; single-cycle strobe per byte.
- print_req  in  1  request to drain buffer; level sampled per cycle.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART transmitter accepts tx_data this cycle.
- count  out  $clog2(DEPTH)+1  bytes currently stored in FIFO.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a write was dropped.
- busy  out  1  drain in progress or output byte not yet accepted.

Behaviour:
- Reset (rst=0, async):
  - FIFO pointers = 0, count = 0, empty = 1, full = 0, overflow = 0.
  - tx_valid = 0, tx_data = 0x00, state = IDLE, pend = 0, busy = 0.
- Write:
  - If wr_valid and !full, the byte is stored at wr_ptr and wr_ptr increments (wraps modulo DEPTH).
  - If wr_valid and full, the byte is dropped and overflow is set. This applies even when a pop occurs in the same cycle, because full is evaluated on the pre-cycle count.
  - Writes are accepted in every state.
- Count: +1 on accepted write, -1 on pop, unchanged when both happen in the same cycle.
- Output register: tx_data and tx_valid are registered.
  - A slot is free when !tx_valid || tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable.
  - When a slot is free and no new byte is loaded, tx_valid drops to 0.
- FSM states: IDLE, DRAIN, CR, LF.
  - IDLE: if (print_req || pend) and no output byte is pending (tx_valid=0 or being accepted), go to DRAIN, clear pend, clear overflow.
  - DRAIN: on each free slot, if the FIFO is non-empty, pop the byte at rd_ptr into tx_data and set tx_valid.
  - DRAIN, FIFO empty on a free slot: go to CR if ADD_CRLF, else IDLE.
  - Bytes written during DRAIN are sent in the same pass.
  - CR: on free slot load 0x0D, go to LF.
  - LF: on free slot load 0x0A, go to IDLE. tx_valid stays high in IDLE until accepted.
- Latency: print_req sampled high in cycle N from IDLE with tx_valid=0 and a non-empty FIFO gives tx_valid=1 with the first byte in cycle N+1. Throughput is one byte per cycle while tx_ready=1.
- print_req while busy sets pend. One further pass starts after the current pass completes; multiple requests collapse into one.
- busy = (state != IDLE) || tx_valid.
- Empty FIFO at print: DRAIN exits immediately; the pass emits only 0D 0A (ADD_CRLF=1), or nothing (ADD_CRLF=0).
- Reset mid-drain: all state is cleared immediately, stored bytes are discarded, tx_valid drops asynchronously.

Decomposition:
- Shared package holds:
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - the FSM state enum (IDLE, DRAIN, CR, LF), 2-bit.
- One natural sub-module: sync_fifo8 (DEPTH-parameterised byte FIFO).
  - Ports: push, pop, din, dout, count, full, empty; async active-low reset.
  - dout is read combinationally at rd_ptr (show-ahead).
- tx_line_buf contains the FSM, output register and overflow/pend flags.

Test Plan:
- Write 0x48, 0x69, pulse print_req, tx_ready=1 -> tx_data sequence 48,69,0D,0A on consecutive cycles; then busy=0, empty=1.
- DEPTH=4: write 0x41..0x45 back-to-back -> full=1 after the 4th byte, overflow=1 after the 5th; print -> 41,42,43,44,0D,0A; overflow clears on print acceptance.
- Backpressure: during drain of 0x31,0x32 hold tx_ready=0 for 3 cycles on the first byte -> tx_data=0x31 stable with tx_valid=1 throughout; 0x32 follows the cycle after acceptance.
- print_req pulsed again mid-drain with no new writes -> after the first pass's 0A, a second pass emits exactly 0D,0A.
- print with empty FIFO, ADD_CRLF=0 -> tx_valid never asserts, busy never asserts.
- Write 3 bytes, print, assert rst=0 after the first byte is sent -> tx_valid=0 and count=0 immediately; after release a new print emits only 0D,0A.
